// File: rtl/alu_driver.sv
// Command FIFO plus IDLE/EXEC/RESP sequencer that drives a 4-bit ALU and returns its results in order.
// Define ALU_DRIVER_CHECK_EN to add an internal result model and a sticky err flag.
package alu_driver_pkg;
    typedef enum logic [2:0] {
        ADD            = 3'd0,
        SUB            = 3'd1,
        BITWISE_INVERT = 3'd2,
        REDUCTION      = 3'd3
    } opcode_e;

    typedef struct packed {
        opcode_e    op;
        logic [3:0] a;
        logic [3:0] b;
    } cmd_t;
endpackage

module alu_driver
    import alu_driver_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  opcode_e    cmd_opcode,
    input  logic [3:0] cmd_a,
    input  logic [3:0] cmd_b,
    output opcode_e    alu_opcode,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    input  logic [3:0] alu_c,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [3:0] rsp_data,
    output opcode_e    rsp_opcode,
    output logic       busy,
    output logic       err
);
    localparam int          AW       = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

    state_e        state_reg;
    cmd_t          fifo_mem [DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [AW:0]   count_reg;
    opcode_e       alu_opcode_reg;
    logic [3:0]    alu_a_reg;
    logic [3:0]    alu_b_reg;
    logic          rsp_valid_reg;
    logic [3:0]    rsp_data_reg;
    opcode_e       rsp_opcode_reg;

    cmd_t head;
    logic fifo_empty;
    logic push;
    logic pop;

    assign head       = fifo_mem[rd_ptr_reg];
    assign fifo_empty = (count_reg == '0);
    assign cmd_ready  = (count_reg != FULL_CNT);
    assign push       = cmd_valid && cmd_ready;
    // A new command is issued from IDLE, or straight after a consumed response.
    assign pop        = !fifo_empty && ((state_reg == IDLE) || ((state_reg == RESP) && rsp_ready));

    assign alu_opcode = alu_opcode_reg;
    assign alu_a      = alu_a_reg;
    assign alu_b      = alu_b_reg;
    assign rsp_valid  = rsp_valid_reg;
    assign rsp_data   = rsp_data_reg;
    assign rsp_opcode = rsp_opcode_reg;
    assign busy       = !fifo_empty || (state_reg != IDLE);

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_reg] <= '{op: cmd_opcode, a: cmd_a, b: cmd_b};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            count_reg      <= '0;
            alu_opcode_reg <= ADD;
            alu_a_reg      <= 4'h0;
            alu_b_reg      <= 4'h0;
            rsp_valid_reg  <= 1'b0;
            rsp_data_reg   <= 4'h0;
            rsp_opcode_reg <= ADD;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop) begin
                rd_ptr_reg     <= rd_ptr_reg + AW'(1);
                alu_opcode_reg <= head.op;
                alu_a_reg      <= head.a;
                alu_b_reg      <= head.b;
            end
            unique case ({push, pop})
                2'b10:   count_reg <= count_reg + (AW + 1)'(1);
                2'b01:   count_reg <= count_reg - (AW + 1)'(1);
                default: count_reg <= count_reg;
            endcase

            unique case (state_reg)
                IDLE: begin
                    if (pop) begin
                        state_reg <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_data_reg   <= alu_c;
                    rsp_opcode_reg <= alu_opcode_reg;
                    rsp_valid_reg  <= 1'b1;
                    state_reg      <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_reg <= 1'b0;
                        state_reg     <= pop ? EXEC : IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

`ifdef ALU_DRIVER_CHECK_EN
    logic [3:0] model_c;
    logic       err_reg;

    always_comb begin
        model_c = 4'h0;
        case (alu_opcode_reg)
            ADD:            model_c = alu_a_reg + alu_b_reg;
            SUB:            model_c = alu_a_reg - alu_b_reg;
            BITWISE_INVERT: model_c = ~alu_a_reg;
            REDUCTION:      model_c = {3'b000, |alu_b_reg};
            default:        model_c = 4'h0;
        endcase
    end

    // Operands have been stable for a full cycle by EXEC, so alu_c is settled there.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_reg <= 1'b0;
        end else if ((state_reg == EXEC) && (alu_c != model_c)) begin
            err_reg <= 1'b1;
        end
    end

    assign err = err_reg;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_alu_driver.sv
// Scoreboard bench for alu_driver: directed scenarios, then randomized traffic with random back-pressure.
module tb_alu_driver;
    import alu_driver_pkg::*;

    localparam int DEPTH = 4;

    logic       clk;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    opcode_e    cmd_opcode;
    logic [3:0] cmd_a;
    logic [3:0] cmd_b;
    opcode_e    alu_opcode;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [3:0] alu_c;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [3:0] rsp_data;
    opcode_e    rsp_opcode;
    logic       busy;
    logic       err;
    logic       fault_en;

    typedef struct {
        opcode_e    op;
        logic [3:0] data;
        int         acc_cyc;
    } exp_t;

    exp_t       sb_q[$];
    logic [3:0] data_log[$];
    int         rise_q[$];
    exp_t       mon_e;
    exp_t       acc_e;
    int         n_tests = 0;
    int         n_fail = 0;
    int         cyc = 0;
    int         rise_cyc = 0;
    int         last_lat = 0;
    logic       prev_valid;
    logic       hold_v;
    logic [3:0] held_data;
    opcode_e    held_op;
    bit         rand_done;

    alu_driver #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_opcode(cmd_opcode),
        .cmd_a     (cmd_a),
        .cmd_b     (cmd_b),
        .alu_opcode(alu_opcode),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_c     (alu_c),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_opcode(rsp_opcode),
        .busy      (busy),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bench-side ALU; fault_en makes it answer 4'hF for ADD 1+1.
    always_comb begin
        alu_c = 4'h0;
        case (alu_opcode)
            ADD:            alu_c = alu_a + alu_b;
            SUB:            alu_c = alu_a + ~alu_b + 4'h1;
            BITWISE_INVERT: alu_c = alu_a ^ 4'hF;
            REDUCTION:      alu_c = {3'b000, (alu_b != 4'h0)};
            default:        alu_c = 4'h0;
        endcase
        if (fault_en && alu_opcode == ADD && alu_a == 4'h1 && alu_b == 4'h1) begin
            alu_c = 4'hF;
        end
    end

    function automatic logic [3:0] ref_result(opcode_e op, int a, int b);
        int r;
        case (op)
            ADD:            r = (a + b) % 16;
            SUB:            r = (a - b + 16) % 16;
            BITWISE_INVERT: r = 15 - a;
            REDUCTION:      r = (b != 0) ? 1 : 0;
            default:        r = 0;
        endcase
        return r[3:0];
    endfunction

    task automatic check(string name, int act, int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Monitor + scoreboard: everything is sampled at the falling edge, ahead of the edge that acts on it.
    initial begin
        prev_valid = 1'b0;
        hold_v     = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                sb_q.delete();
                prev_valid = 1'b0;
                hold_v     = 1'b0;
            end else begin
                if (hold_v) begin
                    check("rsp_hold_valid", int'(rsp_valid), 1);
                    check("rsp_hold_data", int'(rsp_data), int'(held_data));
                    check("rsp_hold_opcode", int'(rsp_opcode), int'(held_op));
                end
                if (rsp_valid && !prev_valid) begin
                    rise_cyc = cyc;
                    rise_q.push_back(cyc);
                end
                if (rsp_valid && rsp_ready) begin
                    if (sb_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL rsp_unexpected: got data %0d opcode %0d, expected no response", rsp_data, rsp_opcode);
                    end else begin
                        mon_e = sb_q.pop_front();
                        check("rsp_data", int'(rsp_data), int'(mon_e.data));
                        check("rsp_opcode", int'(rsp_opcode), int'(mon_e.op));
                        last_lat = rise_cyc - mon_e.acc_cyc;
                        check("rsp_latency_min", int'(last_lat >= 3), 1);
                    end
                    data_log.push_back(rsp_data);
                end
                hold_v     = rsp_valid && !rsp_ready;
                held_data  = rsp_data;
                held_op    = rsp_opcode;
                prev_valid = rsp_valid;
                if (cmd_valid && cmd_ready) begin
                    acc_e.op      = cmd_opcode;
                    acc_e.data    = (fault_en && cmd_opcode == ADD && cmd_a == 4'h1 && cmd_b == 4'h1)
                                    ? 4'hF : ref_result(cmd_opcode, int'(cmd_a), int'(cmd_b));
                    acc_e.acc_cyc = cyc;
                    sb_q.push_back(acc_e);
                end
            end
        end
    end

    task automatic idle(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic try_send(opcode_e op, logic [3:0] a, logic [3:0] b, int limit, output bit ok);
        cmd_opcode = op;
        cmd_a      = a;
        cmd_b      = b;
        cmd_valid  = 1'b1;
        ok         = 1'b0;
        for (int i = 0; i < limit && !ok; i++) begin
            @(negedge clk);
            if (cmd_ready) ok = 1'b1;
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic send(opcode_e op, logic [3:0] a, logic [3:0] b);
        bit ok;
        try_send(op, a, b, 200, ok);
        check("send_accept", int'(ok), 1);
    endtask

    function automatic opcode_e rand_op();
        logic [2:0] v;
        v = 3'($urandom_range(0, 7));
        return opcode_e'(v);
    endfunction

    task automatic send_rand();
        send(rand_op(), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 400 && !done; i++) begin
            @(negedge clk);
            if (sb_q.size() == 0 && !busy) done = 1'b1;
        end
        check("drain_done", int'(done), 1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int accepted;

        rst        = 1'b1;
        cmd_valid  = 1'b0;
        cmd_opcode = ADD;
        cmd_a      = 4'h0;
        cmd_b      = 4'h0;
        rsp_ready  = 1'b0;
        fault_en   = 1'b0;
        rand_done  = 1'b0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_cmd_ready", int'(cmd_ready), 1);
        check("reset_rsp_valid", int'(rsp_valid), 0);
        check("reset_rsp_data", int'(rsp_data), 0);
        check("reset_rsp_opcode", int'(rsp_opcode), int'(ADD));
        check("reset_alu_opcode", int'(alu_opcode), int'(ADD));
        check("reset_alu_a", int'(alu_a), 0);
        check("reset_alu_b", int'(alu_b), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_err", int'(err), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(1);

        // Single ADD: 7+9 wraps to 0, response three cycles after acceptance.
        rsp_ready = 1'b1;
        data_log.delete();
        send(ADD, 4'h7, 4'h9);
        drain();
        check("first_latency", last_lat, 3);
        check("first_count", data_log.size(), 1);
        if (data_log.size() == 1) check("first_data", int'(data_log[0]), 0);

        // Back-to-back commands come out every second cycle.
        data_log.delete();
        rise_q.delete();
        send(SUB, 4'h3, 4'h5);
        send(BITWISE_INVERT, 4'h5, 4'h0);
        send(REDUCTION, 4'h6, 4'h0);
        send(REDUCTION, 4'h2, 4'h8);
        drain();
        check("b2b_count", data_log.size(), 4);
        if (data_log.size() == 4) begin
            check("b2b_data0", int'(data_log[0]), 14);
            check("b2b_data1", int'(data_log[1]), 10);
            check("b2b_data2", int'(data_log[2]), 0);
            check("b2b_data3", int'(data_log[3]), 1);
        end
        if (rise_q.size() == 4) begin
            for (int i = 0; i < 3; i++) check("b2b_spacing", rise_q[i+1] - rise_q[i], 2);
        end else begin
            check("b2b_rises", rise_q.size(), 4);
        end

        // Back-pressure: one held in RESP plus DEPTH queued, the next is refused.
        rsp_ready = 1'b0;
        data_log.delete();
        accepted = 0;
        for (int i = 0; i < 6; i++) begin
            try_send(rand_op(), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4, ok);
            if (ok) accepted++;
        end
        @(negedge clk);
        check("full_accepted", accepted, DEPTH + 1);
        check("full_cmd_ready", int'(cmd_ready), 0);
        check("full_busy", int'(busy), 1);
        @(posedge clk);
        #1;
        idle(3);
        rsp_ready = 1'b1;
        drain();
        check("full_returned", data_log.size(), DEPTH + 1);

        // Reset while a response is pending and three commands are queued.
        rsp_ready = 1'b0;
        data_log.delete();
        for (int i = 0; i < 4; i++) send_rand();
        idle(3);
        @(negedge clk);
        check("prerst_rsp_valid", int'(rsp_valid), 1);
        check("prerst_cmd_ready", int'(cmd_ready), 1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("postrst_rsp_valid", int'(rsp_valid), 0);
        check("postrst_busy", int'(busy), 0);
        check("postrst_cmd_ready", int'(cmd_ready), 1);
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        send(ADD, 4'h1, 4'h1);
        drain();
        check("postrst_count", data_log.size(), 1);
        if (data_log.size() == 1) check("postrst_data", int'(data_log[0]), 2);

        // Push and pop on the same edge at level 2, then fill to prove the level held.
        rsp_ready = 1'b0;
        data_log.delete();
        for (int i = 0; i < 3; i++) send_rand();
        idle(3);
        cmd_opcode = rand_op();
        cmd_a      = 4'($urandom_range(0, 15));
        cmd_b      = 4'($urandom_range(0, 15));
        cmd_valid  = 1'b1;
        rsp_ready  = 1'b1;
        @(negedge clk);
        check("simul_cmd_ready", int'(cmd_ready), 1);
        check("simul_rsp_valid", int'(rsp_valid), 1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        rsp_ready = 1'b0;
        send_rand();
        @(negedge clk);
        check("simul_level3_ready", int'(cmd_ready), 1);
        @(posedge clk);
        #1;
        send_rand();
        @(negedge clk);
        check("simul_level4_ready", int'(cmd_ready), 0);
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        drain();
        check("simul_returned", data_log.size(), 6);

        // Randomized traffic with random response back-pressure.
        data_log.delete();
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    idle($urandom_range(0, 2));
                    send_rand();
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk);
                    #1;
                    rsp_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        rsp_ready = 1'b1;
        drain();
        check("rand_returned", data_log.size(), 300);
        check("rand_err", int'(err), 0);

`ifdef ALU_DRIVER_CHECK_EN
        fault_en = 1'b1;
        send(ADD, 4'h1, 4'h1);
        drain();
        fault_en = 1'b0;
        check("chk_err_set", int'(err), 1);
        send(ADD, 4'h2, 4'h3);
        send(SUB, 4'h9, 4'h4);
        drain();
        check("chk_err_sticky", int'(err), 1);
`else
        check("nochk_err_zero", int'(err), 0);
`endif

        check("final_scoreboard_empty", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_driver.md
Name: alu_driver

Overview:
Initiator side of the 4-bit ALU operand/opcode interface. It accepts ALU commands over a valid/ready stream and buffers them in a small FIFO. It drives one command at a time onto registered opcode/a/b outputs, samples the ALU's combinational result, and returns it over a valid/ready response stream. It sits between a command source (test sequencer or control unit) and the ALU instance.

Parameters:
DEPTH, 4, command FIFO entries; power of two, minimum 2.

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
cmd_valid  input  1  command present
cmd_ready  output  1  command accepted when cmd_valid && cmd_ready
cmd_opcode  input  opcode_e  requested operation (enum from enum.svh)
cmd_a  input  4  operand a
cmd_b  input  4  operand b
alu_opcode  output  opcode_e  registered opcode to ALU
alu_a  output  4  registered operand a to ALU
alu_b  output  4  registered operand b to ALU
alu_c  input  4  ALU combinational result
rsp_valid  output  1  result available
rsp_ready  input  1  result consumed when rsp_valid && rsp_ready
rsp_data  output  4  captured result
rsp_opcode  output  opcode_e  opcode that produced rsp_data
busy  output  1  high when FIFO is non-empty or state != IDLE
err  output  1  sticky checker mismatch (see Optional Feature)

Behaviour:
- Single clock clk. Reset rst is synchronous and active-high. All state is sampled on rising clk.
- Reset values: cmd_ready=1, rsp_valid=0, rsp_data=0, rsp_opcode=ADD, alu_opcode=ADD, alu_a=0, alu_b=0, busy=0, err=0. FIFO is empty; state is IDLE.
- Reset asserted mid-operation discards all queued commands and any pending response. No partial handshake completes in the reset cycle.
- FIFO:
  - cmd_ready = !full. It is registered-state derived and never depends on cmd_valid.
  - Push and pop in the same cycle are legal at any level. When full, cmd_ready=0, so a same-cycle pop does not admit a new push.
  - Pointers wrap modulo DEPTH. A count of 0..DEPTH distinguishes full from empty.
- FSM with states IDLE, EXEC, RESP:
  - IDLE: if FIFO is non-empty, pop the head into alu_opcode/alu_a/alu_b and go to EXEC; otherwise stay in IDLE.
  - EXEC: ALU inputs have been stable for one cycle. Latch alu_c into rsp_data and alu_opcode into rsp_opcode, set rsp_valid=1, and go to RESP.
  - RESP: hold rsp_valid, rsp_data and rsp_opcode stable until rsp_ready. On handshake:
    - if the FIFO is non-empty, pop the next command into the alu_* registers, clear rsp_valid, and go to EXEC;
    - otherwise clear rsp_valid and go to IDLE.
  - The alu_* registers change only on a pop, so ALU inputs are stable throughout EXEC and RESP.
- Latency: command accepted in cycle N (empty FIFO, IDLE) → popped at edge N+1 → rsp_valid high in cycle N+3.
- Throughput: one result per 2 cycles with rsp_ready held high.
- Ordering: responses are returned strictly in command order, with no drops or duplicates.
- Opcodes outside the enum are forwarded unchanged; rsp_data is whatever the ALU returns (0 for the current ALU).
- Arithmetic is owned by the ALU; the driver does no width extension.

Optional Feature:
ALU_DRIVER_CHECK_EN
- Defined: an internal reference model computes the expected result from alu_opcode/alu_a/alu_b:
  - ADD: (a+b) mod 16
  - SUB: (a−b) mod 16
  - BITWISE_INVERT: ~a
  - REDUCTION: {3'b0, |b}
  - other: 0
- The model is compared with alu_c in EXEC. A mismatch sets err=1 at the next edge. err stays set until rst.
- Not defined: err is tied to 0 and no model logic is generated. Timing and all other outputs are identical in both builds.

Test Plan:
- Reset, then ADD a=7 b=9 with rsp_ready=1 → rsp_valid rises 3 cycles after accept, rsp_data=4'h0, rsp_opcode=ADD.
- Back-to-back SUB a=3 b=5, BITWISE_INVERT a=4'h5, REDUCTION b=0, REDUCTION b=4'h8 → rsp_data sequence 4'hE, 4'hA, 4'h0, 4'h1, in order, spaced 2 cycles apart.
- rsp_ready=0, offer 6 commands (DEPTH=4) → 5 accepted (1 held in RESP, 4 queued), cmd_ready=0 on the 6th. Release rsp_ready → all 5 results returned in order, and rsp_data is stable while stalled.
- Assert rst for 1 cycle while in RESP with 3 queued → next cycle rsp_valid=0, busy=0, cmd_ready=1. A subsequent ADD 1+1 returns 4'h2 with no stale responses.
- Simultaneous push and pop with FIFO at level 2 → level unchanged, no lost command, wrap-around past index DEPTH−1 is correct.
- With ALU_DRIVER_CHECK_EN defined and the ALU forced to return 4'hF for ADD 1+1 → err=1 after EXEC and still 1 after later correct results. Without the macro, err=0.
